// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared types and constants for the BCD countdown timer
package bcd_timer_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with borrow output
module bcd_down_digit
    import bcd_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               dec_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_digit;
        end else if (dec_in) begin
            digit <= (digit == '0) ? BCD_MAX : digit - 1'b1;
        end
    end

    assign borrow_out = dec_in & (digit == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - cascaded BCD countdown timer with reload and stop modes
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    input  logic                          en,
    input  logic                          auto_reload,
    output logic [DIGIT_W*NUM_DIGITS-1:0] q,
    output logic                          zero,
    output logic                          busy,
    output logic                          done,
    output logic                          load_err
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    state_t          state, state_next;
    logic [W-1:0]    reload;
    logic [W-1:0]    clamped;
    logic            bad_digit;
    logic [W-1:0]    digit_src;
    logic            digit_load;
    logic            expire;
    logic [NUM_DIGITS:0] borrow;

    always_comb begin
        clamped   = '0;
        bad_digit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
            bad_digit = bad_digit | (load_val[i*DIGIT_W +: DIGIT_W] > BCD_MAX);
        end
    end

    // A borrow out of the top digit means every digit was zero: that is expiry.
    assign borrow[0]  = (state == ST_RUN) & en & ~load;
    assign expire     = borrow[NUM_DIGITS];
    assign digit_load = load | expire;
    assign digit_src  = load ? clamped : (auto_reload ? reload : '0);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (digit_load),
            .load_digit (digit_src[g*DIGIT_W +: DIGIT_W]),
            .dec_in     (borrow[g]),
            .digit      (q[g*DIGIT_W +: DIGIT_W]),
            .borrow_out (borrow[g+1])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (load) state_next = ST_RUN;
            ST_RUN: begin
                if (!load && expire && !auto_reload) state_next = ST_DONE;
            end
            ST_DONE: if (load) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            reload   <= '0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= expire;
            load_err <= load & bad_digit;
            if (load) reload <= clamped;
        end
    end

    assign zero = (q == '0);
    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for the BCD countdown timer
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        load2 = 0, en2 = 0, ar2 = 0;
    logic [7:0]  lv2 = '0;
    logic [7:0]  q2;
    logic        zero2, busy2, done2, lerr2;

    logic        load3 = 0, en3 = 0, ar3 = 0;
    logic [11:0] lv3 = '0;
    logic [11:0] q3;
    logic        zero3, busy3, done3, lerr3;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .load(load2), .load_val(lv2), .en(en2),
        .auto_reload(ar2), .q(q2), .zero(zero2), .busy(busy2), .done(done2),
        .load_err(lerr2)
    );

    bcd_countdown_timer #(.NUM_DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .load(load3), .load_val(lv3), .en(en3),
        .auto_reload(ar3), .q(q3), .zero(zero3), .busy(busy3), .done(done3),
        .load_err(lerr3)
    );

    typedef struct {
        int          id;
        logic [31:0] q;
        bit          done;
        bit          busy;
        bit          lerr;
        bit          zero;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: count held as a plain integer, state 0=idle 1=run 2=done
    int m_val[2], m_reload[2], m_state[2];
    bit m_done[2], m_lerr[2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd_to_int(input logic [31:0] b, input int nd);
        int v = 0;
        int d;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic bit has_bad(input logic [31:0] b, input int nd);
        bit r = 0;
        for (int i = 0; i < nd; i++) if (b[4*i +: 4] > 4'd9) r = 1;
        return r;
    endfunction

    function automatic logic [31:0] int_to_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_reload[i] = 0; m_state[i] = 0;
            m_done[i] = 0; m_lerr[i] = 0;
        end
    endtask

    task automatic step(input int id, input bit ld, input logic [31:0] lv, input bit e, input bit ar);
        exp_t x;
        int   nd;
        @(negedge clk);
        if (id == 0) begin
            load2 = ld; lv2 = lv[7:0]; en2 = e; ar2 = ar; load3 = 0; en3 = 0;
        end else begin
            load3 = ld; lv3 = lv[11:0]; en3 = e; ar3 = ar; load2 = 0; en2 = 0;
        end
        nd = (id == 0) ? 2 : 3;
        m_done[id] = 0;
        m_lerr[id] = 0;
        if (ld) begin
            m_val[id]    = bcd_to_int(lv, nd);
            m_reload[id] = m_val[id];
            m_state[id]  = 1;
            m_lerr[id]   = has_bad(lv, nd);
        end else if (m_state[id] == 1 && e) begin
            if (m_val[id] != 0) m_val[id] = m_val[id] - 1;
            else begin
                m_done[id] = 1;
                if (ar) m_val[id] = m_reload[id];
                else    m_state[id] = 2;
            end
        end
        x.id   = id;
        x.q    = int_to_bcd(m_val[id], nd);
        x.done = m_done[id];
        x.busy = (m_state[id] == 1);
        x.lerr = m_lerr[id];
        x.zero = (m_val[id] == 0);
        sb.push_back(x);

        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (x.id == 0) begin
            check_eq("q",        {24'h0, q2},   x.q);
            check_eq("done",     32'(done2),    32'(x.done));
            check_eq("busy",     32'(busy2),    32'(x.busy));
            check_eq("load_err", 32'(lerr2),    32'(x.lerr));
            check_eq("zero",     32'(zero2),    32'(x.zero));
        end else begin
            check_eq("q3",        {20'h0, q3},  x.q);
            check_eq("done3",     32'(done3),   32'(x.done));
            check_eq("busy3",     32'(busy3),   32'(x.busy));
            check_eq("load_err3", 32'(lerr3),   32'(x.lerr));
            check_eq("zero3",     32'(zero3),   32'(x.zero));
        end
    endtask

    initial begin
        model_reset();
        #1;
        check_eq("rst_q",    {24'h0, q2}, 32'h0);
        check_eq("rst_busy", 32'(busy2),  32'h0);
        check_eq("rst_zero", 32'(zero2),  32'h1);
        check_eq("rst_done", 32'(done2),  32'h0);
        check_eq("rst_lerr", 32'(lerr2),  32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Auto-reload from 09: period of 10 enabled cycles
        step(0, 1, 32'h09, 0, 1);
        for (int i = 0; i < 22; i++) step(0, 0, 32'h0, 1, 1);

        // Stop-at-zero from 20, then en held high in DONE
        step(0, 1, 32'h20, 0, 0);
        for (int i = 0; i < 21; i++) step(0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++)  step(0, 0, 32'h0, 1, 1);

        // Out-of-range digit clamped; load wins over en
        step(0, 1, 32'h3A, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        step(0, 1, 32'hFF, 0, 0);

        // Gated decrement, then mid-count reload
        step(0, 1, 32'h55, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 32'h0, (i % 2 == 0), 0);
        step(0, 1, 32'h12, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 0);

        // Zero load expires on next enabled cycle
        step(0, 1, 32'h00, 0, 0);
        step(0, 0, 32'h0, 1, 0);

        // Reset between edges mid-count
        step(0, 1, 32'h47, 0, 1);
        step(0, 0, 32'h0, 1, 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_q",    {24'h0, q2}, 32'h0);
        check_eq("midrst_busy", 32'(busy2),  32'h0);
        check_eq("midrst_done", 32'(done2),  32'h0);
        @(posedge clk);
        #1;
        check_eq("midrst_done_edge", 32'(done2), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1, 1);

        // Three-digit borrow chain
        step(1, 1, 32'h100, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 The block SHALL take parameter NUM_DIGITS, default 2, meaning the number of cascaded BCD digits (range 1-8).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  when high, load_val is captured as both the count and the reload value.
REQ-005 load_val  input  4*NUM_DIGITS  packed BCD, LSD in bits [3:0].
REQ-006 en  input  1  count-down strobe; one decrement per cycle when high.
REQ-007 auto_reload  input  1  selects wrap-to-reload (1) or stop-at-zero (0) on expiry.
REQ-008 q  output  4*NUM_DIGITS  current packed BCD count.
REQ-009 zero  output  1  combinational, high when q is all zeros.
REQ-010 busy  output  1  high while state is RUN.
REQ-011 done  output  1  registered one-cycle pulse on each expiry event.
REQ-012 load_err  output  1  registered one-cycle pulse when a load contains any digit above 9.

Function
REQ-013 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 Transitions: IDLE->RUN on load; RUN->DONE on expiry with auto_reload=0; DONE->RUN on load; RUN stays in RUN on load, on wrap, and while en=0.
REQ-015 On load, the block SHALL write q and the internal reload register in the same edge, from any state.
REQ-016 On load, any digit above 9 SHALL be clamped to 9 in both q and the reload register, and load_err SHALL pulse for one cycle.
REQ-017 load SHALL take priority over en in the same cycle, with no decrement applied.
REQ-018 In RUN with en=1 and q nonzero, q SHALL decrement by one in BCD:
- the LSD always decrements;
- a digit at 0 becomes 9 and borrows from the next digit;
- the result SHALL be visible the cycle after the enabled edge.
REQ-019 In RUN with en=1 and q=0, an expiry event SHALL occur.
REQ-020 On expiry with auto_reload=1, q SHALL take the reload value and the state SHALL remain RUN.
- Resulting period: reload+1 enabled cycles.
- Example: reload=09 counts 9..0 with period 10.
REQ-021 On expiry with auto_reload=0, q SHALL hold 0 and the state SHALL go to DONE.
REQ-022 done SHALL be high for exactly the one cycle following the expiry edge.
REQ-023 In IDLE and DONE, en SHALL be ignored and q SHALL hold.
REQ-024 A load of all zeros SHALL enter RUN with q=0, so the next enabled cycle expires.
REQ-025 auto_reload SHALL be sampled only at the expiry edge.
REQ-026 q SHALL never hold a non-BCD digit.

Reset
REQ-027 While reset_n=0, the block SHALL immediately hold: state IDLE, q=0, reload register 0, done=0, load_err=0.
- busy=0 and zero=1 follow from that state.
REQ-028 Reset asserted mid-count SHALL abort the count with no done pulse.
REQ-029 Reset release SHALL take effect at the next clk edge, with no spurious decrement.

Structure
REQ-030 A shared package bcd_timer_pkg SHALL hold:
- the state enum;
- DIGIT_W=4;
- BCD_MAX=9.
REQ-031 The block SHALL use one sub-module, bcd_down_digit, instantiated NUM_DIGITS times in a borrow chain.
- Ports: clk, reset_n, load, load_digit, dec_in, digit, borrow_out.
- borrow_out = dec_in AND digit==0.
REQ-032 The FSM, reload register, clamp logic and output pulses SHALL live in the top module.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Load 09, auto_reload=1, en held high: q reads 9,8,...,0,9; done pulses once every 10 cycles, in the cycle q returns to 9.
- Load 20, auto_reload=0, en high: q reads 20,19,18,...,10,09,...,00; done pulses once; state DONE; q holds 00 and busy=0 while en stays high.
- Load 3A: q=39 and load_err pulses; load with en high on the same cycle: no decrement that cycle.
- Count from 55 with en toggling every other cycle: q decrements only on enabled edges; reload to 12 mid-count restarts from 12.
- reset_n driven low between edges mid-count: q=00 and busy=0 immediately with no done; after release, en alone leaves q at 00 in IDLE.
- NUM_DIGITS=3, load 100, en high: q reaches 099 after one cycle, with borrow through two digits.
